dsp_mac_seq: RTL
================

DSP_MAC_SEQ -- requirements
Module: dsp_mac_seq

Interface
REQ-001 Parameter LEN_W, default 8: width of the sample-count input len.
REQ-002 Parameter OPM_DLY, default 2: cycles from driving dsp_a/dsp_b until dsp_opmode must carry that sample's opcode.
REQ-003 Parameter PIPE_LAT, default 3: cycles from driving dsp_a/dsp_b until dsp_p includes that sample's product.
REQ-004 clk  in  1  sole clock, rising edge.
REQ-005 RST  in  1  reset, synchronous, active-high.
REQ-006 start  in  1  one-cycle request to begin a dot product; sampled only in IDLE.
REQ-007 len  in  LEN_W  number of sample pairs; captured with start.
REQ-008 in_valid / in_ready  in / out  1 / 1  sample handshake; a transfer occurs when both are high.
REQ-009 in_a, in_b  in  18 each  signed operands.
REQ-010 dsp_a, dsp_b  out  18 each  operands to the DSP48A1 A/B ports.
REQ-011 dsp_opmode  out  8  DSP OPMODE.
REQ-012 dsp_carryin  out  1  carry-in, always 0.
REQ-013 dsp_rst  out  1  drives all DSP RSTx inputs.
REQ-014 dsp_ce  out  1  drives all DSP CEx inputs.
REQ-015 dsp_p  in  48  DSP P output.
REQ-016 busy  out  1  high in any state except IDLE.
REQ-017 result  out  48  final accumulation.
REQ-018 result_valid  out  1  one-cycle pulse when result updates.

Function
REQ-019 The block SHALL implement state machine IDLE -> RUN -> DRAIN -> DONE -> IDLE.
- IDLE->RUN on start with len>0.
- IDLE->DONE on start with len=0.
- RUN->DRAIN on the handshake of sample len.
- DRAIN->DONE after PIPE_LAT cycles.
- DONE->IDLE after one cycle.
REQ-020 in_ready SHALL be high only in RUN while the accepted count is below len.
REQ-021 Each cycle in RUN SHALL be one slot, typed as one of:
- FIRST: first handshake, opmode 8'b0000_0001 (P = M).
- ACC: later handshakes, opmode 8'b0000_1001 (P = P + M).
- HOLD: no handshake, opmode 8'b0000_1000 (P = P).
REQ-022 On a handshake, dsp_a/dsp_b SHALL take in_a/in_b that cycle. On a non-handshake cycle they SHALL hold their previous values.
REQ-023 A slot's opcode SHALL appear on dsp_opmode exactly OPM_DLY cycles after its operands appear on dsp_a/dsp_b. Outside RUN/DRAIN, HOLD SHALL be issued.
REQ-024 Arithmetic is signed 18x18 to 36 bits, sign-extended to 48 bits. Overflow wraps modulo 2^48, with no flag.
REQ-025 dsp_ce SHALL be 1 whenever RST is low. dsp_carryin SHALL be constant 0.
REQ-026 If the last handshake is in cycle k, result SHALL capture dsp_p at cycle k+PIPE_LAT, and result_valid SHALL be high in cycle k+PIPE_LAT+1 only.
REQ-027 For len=0, result SHALL be 0 and result_valid SHALL pulse in the DONE cycle. No DSP opcode other than HOLD is issued.
REQ-028 start while busy SHALL be ignored, and len SHALL not be re-captured.
REQ-029 Bubbles (in_valid low) of any length mid-run SHALL NOT alter the final result.
REQ-030 result SHALL hold its value until the next result_valid.

Reset
REQ-031 While RST is high:
- state = IDLE, in_ready = 0, busy = 0, result = 0, result_valid = 0;
- dsp_a = dsp_b = 0, dsp_opmode = HOLD;
- the opcode delay line is cleared to HOLD;
- dsp_rst = 1.
REQ-032 RST asserted mid-operation SHALL abort the run. No result_valid SHALL follow. The first start after RST is released SHALL be accepted normally.

Structure
REQ-033 Package dsp_ctrl_pkg SHALL hold:
- the state enumeration;
- opmode constants OPM_FIRST, OPM_ACC, OPM_HOLD;
- the 48-bit P width constant.
REQ-034 The OPM_DLY-deep opcode shift register SHALL be a sub-module, dsp_opm_pipe, reset to OPM_HOLD.
REQ-035 The bench SHALL instantiate dsp_mac_seq with the existing DSP top, registers enabled, ASYNC reset type unchanged, and dsp_rst/dsp_ce fanned to all RSTx/CEx ports.

Verification
REQ-036 Basic dot product: len=4, a=1,2,3,4, b=2, back-to-back -> result=20, result_valid PIPE_LAT+1 cycles after the 4th handshake.
REQ-037 Signed, single sample: len=1, a=-3, b=5 -> result=48'hFFFF_FFFF_FFF1.
REQ-038 Bubbles: len=3, a=b=3 with 2-cycle in_valid gaps between samples -> result=27, in_ready low after the 3rd handshake.
REQ-039 Zero length: len=0 -> result=0 and result_valid one cycle after start, with no handshakes.
REQ-040 Start while busy: start pulsed during RUN with len=9 -> ignored; the original len=4 run completes with result=20.
REQ-041 Reset mid-run: RST during the 2nd sample of len=4 -> busy=0, no result_valid. A following len=2 run, a=5, b=6 -> result=60.

Source files
------------

// File: rtl/dsp_ctrl_pkg.sv
// Shared types and constants for the DSP48A1 multiply-accumulate sequencer.
// Opmode encodings select the X mux (M or 0) and the Z mux (P or 0) of the DSP slice.
package dsp_ctrl_pkg;

  localparam int P_W   = 48;
  localparam int OPM_W = 8;

  localparam logic [OPM_W-1:0] OPM_FIRST = 8'b0000_0001;  // P = M
  localparam logic [OPM_W-1:0] OPM_ACC   = 8'b0000_1001;  // P = P + M
  localparam logic [OPM_W-1:0] OPM_HOLD  = 8'b0000_1000;  // P = P

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_e;

  typedef enum logic [1:0] {
    SLOT_HOLD,
    SLOT_FIRST,
    SLOT_ACC
  } slot_e;

  function automatic logic [OPM_W-1:0] slot_opm(input slot_e slot);
    case (slot)
      SLOT_FIRST: return OPM_FIRST;
      SLOT_ACC:   return OPM_ACC;
      default:    return OPM_HOLD;
    endcase
  endfunction

endpackage

// File: rtl/dsp_opm_pipe.sv
// Opcode delay line: aligns each slot's opmode with its operands' progress
// through the DSP input and multiplier registers.
module dsp_opm_pipe
  import dsp_ctrl_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_i,
  input  logic [OPM_W-1:0] opm_i,
  output logic [OPM_W-1:0] opm_o
);

  logic [OPM_W-1:0] sr_q [DEPTH];

  // NOTE: the delay line is reset to HOLD rather than left unreset, so an
  // aborted run cannot leave a FIRST/ACC opcode in flight towards the DSP.
  always_ff @(posedge clk) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        sr_q[i] <= OPM_HOLD;
      end
    end else begin
      // NOTE: non-blocking assignments make every stage sample the previous
      // stage's old value, giving a true DEPTH-cycle shift.
      sr_q[0] <= opm_i;
      for (int i = 1; i < DEPTH; i++) begin
        sr_q[i] <= sr_q[i-1];
      end
    end
  end

  assign opm_o = sr_q[DEPTH-1];

endmodule

// File: rtl/dsp_mac_seq.sv
// Dot-product sequencer for a DSP48A1 slice: accepts len operand pairs, issues
// FIRST/ACC/HOLD opcodes in step with the operands and captures the final P.
module dsp_mac_seq
  import dsp_ctrl_pkg::*;
#(
  parameter int LEN_W    = 8,
  parameter int OPM_DLY  = 2,
  parameter int PIPE_LAT = 3
) (
  input  logic             clk,
  input  logic             RST,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [17:0]      in_a,
  input  logic [17:0]      in_b,
  output logic [17:0]      dsp_a,
  output logic [17:0]      dsp_b,
  output logic [7:0]       dsp_opmode,
  output logic             dsp_carryin,
  output logic             dsp_rst,
  output logic             dsp_ce,
  input  logic [P_W-1:0]   dsp_p,
  output logic             busy,
  output logic [P_W-1:0]   result,
  output logic             result_valid
);

  localparam int DRN_W = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

  state_e             state_q, state_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic [DRN_W-1:0]   drn_q, drn_d;
  logic [17:0]        a_q, a_d;
  logic [17:0]        b_q, b_d;
  logic [P_W-1:0]     result_q, result_d;
  logic               hs;
  logic               last_hs;
  slot_e              slot;
  logic [OPM_W-1:0]   opm_d;
  logic [OPM_W-1:0]   opm_dly;

  assign in_ready = !RST && (state_q == ST_RUN) && (cnt_q < len_q);
  assign hs       = in_valid && in_ready;
  assign last_hs  = hs && (cnt_q == len_q - LEN_W'(1));

  // Operands go straight to the DSP input registers in the handshake cycle;
  // otherwise the last accepted pair is replayed so the A/B ports stay stable.
  assign a_d = hs ? in_a : a_q;
  assign b_d = hs ? in_b : b_q;

  always_comb begin
    // NOTE: every variable gets a default before the case statement so no
    // path leaves one unassigned, which would infer a latch.
    state_d  = state_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    drn_d    = drn_q;
    result_d = result_q;
    slot     = SLOT_HOLD;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          len_d = len;
          cnt_d = '0;
          drn_d = '0;
          if (len == '0) begin
            state_d  = ST_DONE;
            result_d = '0;
          end else begin
            state_d = ST_RUN;
          end
        end
      end

      ST_RUN: begin
        if (hs) begin
          slot  = (cnt_q == '0) ? SLOT_FIRST : SLOT_ACC;
          cnt_d = cnt_q + LEN_W'(1);
          if (last_hs) begin
            state_d = ST_DRAIN;
          end
        end
      end

      // The last product reaches P PIPE_LAT cycles after its handshake.
      ST_DRAIN: begin
        if (drn_q == DRN_W'(PIPE_LAT - 1)) begin
          state_d  = ST_DONE;
          result_d = dsp_p;
        end else begin
          drn_d = drn_q + DRN_W'(1);
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      state_q  <= ST_IDLE;
      len_q    <= '0;
      cnt_q    <= '0;
      drn_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      cnt_q    <= cnt_d;
      drn_q    <= drn_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
    end
  end

  assign opm_d = slot_opm(slot);

  dsp_opm_pipe #(
    .DEPTH (OPM_DLY)
  ) u_opm_pipe (
    .clk   (clk),
    .rst_i (RST),
    .opm_i (opm_d),
    .opm_o (opm_dly)
  );

  assign dsp_a        = RST ? '0 : a_d;
  assign dsp_b        = RST ? '0 : b_d;
  assign dsp_opmode   = RST ? OPM_HOLD : opm_dly;
  assign dsp_carryin  = 1'b0;
  assign dsp_rst      = RST;
  assign dsp_ce       = 1'b1;

  assign busy         = (state_q != ST_IDLE);
  assign result       = result_q;
  assign result_valid = (state_q == ST_DONE);

endmodule
